// File: rtl/systolic_array_param.sv
// -----------------------------------------------------------------------------
// systolic_array_param
//
// Output-stationary N x N systolic matrix multiplier: C (+)= A * B.
// Each PE(i,j) owns one accumulator for C[i][j]. A columns enter from the
// west and B rows from the north, one beat per accepted handshake. They are
// skewed internally so that A[i][k] and B[k][j] meet in PE(i,j) on the same
// shift step.
//
// Handshakes (valid/ready): a beat or row moves on a rising edge where
// valid && ready are both high. The producer holds its payload stable while
// valid is high and ready is low. in_ready does not depend on in_valid, and
// out_valid does not depend on out_ready.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start, acc_en         begin a block; acc_en=0 clears accumulators first
//   in_valid / in_ready   operand beat handshake (LOAD state only)
//   inp_west  [N*DW]      column k of A, lane i = A[i][k]
//   inp_north [N*DW]      row k of B, lane j = B[k][j]
//   out_valid / out_ready result row handshake (READ state only)
//   out_row               index of the row on out_data
//   out_data  [N*AW]      C[out_row][j] in lane j
//   busy                  FSM not in IDLE
//   done                  one-cycle pulse on the first READ cycle
// -----------------------------------------------------------------------------
module systolic_array_param #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      inp_west,
  input  logic [N*DW-1:0]      inp_north,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_row,
  output logic [N*AW-1:0]      out_data,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(N);

  // LOAD counts beats 0..N-1. DRAIN counts 0..2N-2, which is 2N-1 cycles.
  // With N <= 16 the largest value is 30, so 6 bits is enough.
  localparam logic [5:0]    LOAD_LAST  = 6'(N - 1);
  localparam logic [5:0]    DRAIN_LAST = 6'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t        state;
  logic [5:0]    cnt;
  logic [RW-1:0] row_cnt;

  // One shift step moves every skew and PE register by one position.
  // Shifting happens on each accepted beat and on every DRAIN cycle.
  logic shift;
  logic clr_acc;

  assign shift   = ((state == LOAD) && in_valid) || (state == DRAIN);
  assign clr_acc = (state == IDLE) && start && !acc_en;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == READ);
  assign busy      = (state != IDLE);
  assign out_row   = row_cnt;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      row_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt == LOAD_LAST) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state   <= READ;
            cnt     <= '0;
            row_cnt <= '0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        READ: begin
          if (out_ready) begin
            if (row_cnt == ROW_LAST) begin
              state   <= IDLE;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Edge feeds: the live beat during LOAD, and zeros during DRAIN. Zeros
  // flushed through the array leave every operand register clear by the
  // time READ starts.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] west_feed  [N];
  logic [DW-1:0] north_feed [N];
  logic [DW-1:0] a_edge     [N];
  logic [DW-1:0] b_edge     [N];

  for (genvar l = 0; l < N; l++) begin : g_feed
    assign west_feed[l]  = (state == LOAD) ? inp_west[l*DW +: DW]  : '0;
    assign north_feed[l] = (state == LOAD) ? inp_north[l*DW +: DW] : '0;
  end

  // ---------------------------------------------------------------------------
  // Input skew: lane l is delayed by l shift steps. Lane 0 feeds straight
  // through.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < N; l++) begin : g_skew
    if (l == 0) begin : g_direct
      assign a_edge[0] = west_feed[0];
      assign b_edge[0] = north_feed[0];
    end else begin : g_delay
      logic [DW-1:0] sa [l];
      logic [DW-1:0] sb [l];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < l; d++) begin
            sa[d] <= '0;
            sb[d] <= '0;
          end
        end else if (shift) begin
          sa[0] <= west_feed[l];
          sb[0] <= north_feed[l];
          for (int d = 1; d < l; d++) begin
            sa[d] <= sa[d-1];
            sb[d] <= sb[d-1];
          end
        end
      end

      assign a_edge[l] = sa[l-1];
      assign b_edge[l] = sb[l-1];
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid. Each PE registers the operands arriving from its west and north
  // neighbours, and forwards them east and south on the next step. It adds
  // the product of the operands it is already holding. Because of this, the
  // last product (k = N-1 at PE(N-1,N-1)) is added on shift step 3N-1. That
  // is the final DRAIN step.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] a_pe  [N][N];
  logic [DW-1:0] b_pe  [N][N];
  logic [AW-1:0] acc_w [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0]   a_in;
      logic [DW-1:0]   b_in;
      logic [DW-1:0]   a_r;
      logic [DW-1:0]   b_r;
      logic [AW-1:0]   acc_r;
      logic [2*DW-1:0] prod;
      logic [AW-1:0]   prod_t;

      if (j == 0) begin : g_west_edge
        assign a_in = a_edge[i];
      end else begin : g_west_pe
        assign a_in = a_pe[i][j-1];
      end

      if (i == 0) begin : g_north_edge
        assign b_in = b_edge[j];
      end else begin : g_north_pe
        assign b_in = b_pe[i-1][j];
      end

      // Full-width unsigned product. Its low AW bits are added modulo 2^AW.
      assign prod = {{DW{1'b0}}, a_r} * {{DW{1'b0}}, b_r};

      if (AW <= 2 * DW) begin : g_trunc
        assign prod_t = prod[AW-1:0];
      end else begin : g_ext
        assign prod_t = {{(AW - 2 * DW){1'b0}}, prod};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r   <= '0;
          b_r   <= '0;
          acc_r <= '0;
        end else begin
          if (clr_acc) begin
            acc_r <= '0;
          end else if (shift) begin
            acc_r <= acc_r + prod_t;
          end
          if (shift) begin
            a_r <= a_in;
            b_r <= b_in;
          end
        end
      end

      assign a_pe[i][j]  = a_r;
      assign b_pe[i][j]  = b_r;
      assign acc_w[i][j] = acc_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Result row mux. The output is held at zero outside READ.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < N; j++) begin : g_out
    assign out_data[j*AW +: AW] = (state == READ) ? acc_w[row_cnt][j] : '0;
  end

endmodule

// File: tb/tb_systolic_array_param.sv
module tb_systolic_array_param;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT (N=4, DW=AW=32)
  logic              start, acc_en, in_valid, in_ready;
  logic [N*DW-1:0]   inp_west, inp_north;
  logic              out_valid, out_ready;
  logic [1:0]        out_row;
  logic [N*AW-1:0]   out_data;
  logic              busy, done;

  systolic_array_param #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .inp_west(inp_west), .inp_north(inp_north),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .busy(busy), .done(done)
  );

  // Narrow DUT (N=4, DW=AW=8) for the wrap-around case
  logic              s_start, s_acc_en, s_in_valid, s_in_ready;
  logic [31:0]       s_west, s_north;
  logic              s_out_valid, s_out_ready;
  logic [1:0]        s_out_row;
  logic [31:0]       s_out_data;
  logic              s_busy, s_done;

  systolic_array_param #(.N(4), .DW(8), .AW(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .acc_en(s_acc_en),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .inp_west(s_west), .inp_north(s_north),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row(s_out_row), .out_data(s_out_data), .busy(s_busy), .done(s_done)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] a_m   [4][4];
  logic [31:0] b_m   [4][4];
  logic [31:0] exp_c [4][4];
  logic [31:0] got_c [4][4];

  typedef struct {
    logic            ae;
    int              bubble;
    int              stall;
    int              exp_done;
    logic [3:0][31:0] r0;
    logic [31:0]     c33;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic ae, input int bubble, input int stall,
                              input int exp_done, input logic [31:0] r00,
                              input logic [31:0] r01, input logic [31:0] r02,
                              input logic [31:0] r03, input logic [31:0] c33);
    vec_t v;
    v.ae = ae; v.bubble = bubble; v.stall = stall; v.exp_done = exp_done;
    v.r0[0] = r00; v.r0[1] = r01; v.r0[2] = r02; v.r0[3] = r03;
    v.c33 = c33;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = 32'(4 * i + k);
        b_m[i][k] = 32'(4 * i + k);
      end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = (i == k) ? 32'd1 : 32'd0;
        b_m[i][k] = (i == k) ? 32'd1 : 32'd0;
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'd0);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_out_row"},   128'(out_row),   128'd0);
    chk({tag, "_out_data"},  128'(out_data),  128'd0);
    chk({tag, "_busy"},      128'(busy),      128'd0);
    chk({tag, "_done"},      128'(done),      128'd0);
  endtask

  // ---------------- driver: one full block ----------------
  // Cycle 0 is the cycle in which start is driven. The returned done_cyc is
  // the index of the cycle in which done is seen high.
  task automatic run_block(input string tag, input logic ae, input int bubble,
                           input int stall, output int done_cyc);
    int b, bub_left, stall_left, done_cnt, nrows, order_ok;
    logic [127:0] held;
    logic held_v, finished;
    // reference model update
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [31:0] s;
        s = ae ? exp_c[i][j] : 32'd0;
        for (int k = 0; k < 4; k++) s = s + a_m[i][k] * b_m[k][j];
        exp_c[i][j] = s;
        got_c[i][j] = 32'hdead_beef;
      end
    b = 0; bub_left = bubble; stall_left = stall; done_cnt = 0; nrows = 0;
    order_ok = 1; held = '0; held_v = 1'b0; finished = 1'b0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; acc_en = ae; in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (out_valid) begin
        if (out_row == 2'd1) begin
          if (held_v) chk({tag, "_row1_hold"}, out_data, held);
          else begin held = out_data; held_v = 1'b1; end
        end
        if (out_row == 2'd1 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (int'(out_row) != nrows) order_ok = 0;
          for (int j = 0; j < 4; j++) got_c[out_row][j] = out_data[j*32 +: 32];
          nrows++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (in_ready && b < 4) begin
        if (b == 2 && bub_left > 0) begin
          in_valid = 1'b0;
          bub_left--;
        end else begin
          in_valid = 1'b1;
          for (int l = 0; l < 4; l++) begin
            inp_west[l*32 +: 32]  = a_m[l][b];
            inp_north[l*32 +: 32] = b_m[b][l];
          end
          b++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    if (!finished) $display("FAIL %s_timeout: block still busy after 200 cycles", tag);
    chk({tag, "_finished"},    128'(finished), 128'd1);
    chk({tag, "_done_pulses"}, 128'(done_cnt), 128'd1);
    chk({tag, "_row_order"},   128'(order_ok), 128'd1);
    chk({tag, "_rows"},        128'(nrows),    128'd4);
    chk({tag, "_in_ready_end"},  128'(in_ready),  128'd0);
    chk({tag, "_out_valid_end"}, 128'(out_valid), 128'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), 128'(got_c[i][j]), 128'(exp_c[i][j]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; acc_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inp_west = '0; inp_north = '0;
    s_start = 1'b0; s_acc_en = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_west = '0; s_north = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = '0;

    vecs[0] = mk(1'b0, 0, 0, 12,  56,  62,  68,  74,  506);
    vecs[1] = mk(1'b1, 0, 0, 12, 112, 124, 136, 148, 1012);
    vecs[2] = mk(1'b0, 0, 0, 12,  56,  62,  68,  74,  506);
    vecs[3] = mk(1'b0, 3, 0, 15,  56,  62,  68,  74,  506);
    vecs[4] = mk(1'b0, 0, 2, 12,  56,  62,  68,  74,  506);

    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // table-driven blocks
    set_pattern();
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_block(tag, vecs[v].ae, vecs[v].bubble, vecs[v].stall, dc);
      chk({tag, "_done_cycle"}, 128'(dc), 128'(vecs[v].exp_done));
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_row0_%0d", tag, j), 128'(got_c[0][j]), 128'(vecs[v].r0[j]));
      chk({tag, "_c33"}, 128'(got_c[3][3]), 128'(vecs[v].c33));
    end

    // reset in the middle of DRAIN
    @(negedge clk);
    start = 1'b1; acc_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      for (int l = 0; l < 4; l++) begin
        inp_west[l*32 +: 32]  = a_m[l][k];
        inp_north[l*32 +: 32] = b_m[k][l];
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_drain_busy", 128'(busy), 128'd1);
    chk("mid_drain_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_pulse");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = '0;

    // identity block accumulated onto the reset accumulators
    set_identity();
    run_block("ident", 1'b1, 0, 0, dc);
    chk("ident_done_cycle", 128'(dc), 128'd12);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("ident_hand_c%0d%0d", i, j), 128'(got_c[i][j]),
            (i == j) ? 128'd1 : 128'd0);

    // narrow instance: 255*255 products wrap modulo 256
    begin
      int rows8;
      logic fin8;
      rows8 = 0; fin8 = 1'b0;
      @(negedge clk);
      s_start = 1'b1; s_acc_en = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        @(negedge clk);
        s_start = 1'b0;
        if (!s_busy) begin
          fin8 = 1'b1;
          break;
        end
        s_in_valid = s_in_ready;
        s_west = 32'hffff_ffff;
        s_north = 32'hffff_ffff;
        s_out_ready = 1'b1;
        if (s_out_valid) begin
          chk($sformatf("w8_row_idx%0d", rows8), 128'(s_out_row), 128'(rows8));
          for (int j = 0; j < 4; j++)
            chk($sformatf("w8_c%0d%0d", rows8, j), 128'(s_out_data[j*8 +: 8]), 128'd4);
          rows8++;
        end
      end
      s_in_valid = 1'b0;
      if (!fin8) $display("FAIL w8_timeout: narrow block still busy after 200 cycles");
      chk("w8_finished", 128'(fin8), 128'd1);
      chk("w8_rows", 128'(rows8), 128'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
